multiplexed_display_driver: RTL and testbench
=============================================

# multiplexed_display_driver

Parametrised scan driver for multiplexed common-anode seven-segment displays; the next generation of the board's display controller. Adds an exact (non-power-of-two) slot period, anti-ghosting blank time, per-frame PWM brightness, per-digit enable/blink masks and a valid/ready update port with frame-aligned double buffering. Sits between application logic and the segment/anode pins; reuses the existing SevenSegmentEncoder for glyph decoding.

## Interface
- NUM_DIGITS, 8, digits scanned (1..16)
- BLANK_CYCLES, 64, cycles all digits off at start of each slot (≥1)
- STEP_CYCLES, 256, on-time cycles per brightness step (≥1)
- BRIGHTNESS_BITS, 4, brightness width; MAX_LEVEL = 2^BRIGHTNESS_BITS−1
- BLINK_FRAMES, 64, frames per blink half-period (≥1)
- Derived: SLOT_CYCLES = BLANK_CYCLES + MAX_LEVEL*STEP_CYCLES; FRAME_CYCLES = NUM_DIGITS*SLOT_CYCLES
- clock  in  1  system clock
- resetN  in  1  reset; **one clock; reset is synchronous and active-low**
- updateValid  in  1  new display image offered
- updateReady  out  1  shadow buffer free
- updateData  in  4*NUM_DIGITS  nibble per digit, digit 0 in bits [3:0]
- updatePoint  in  NUM_DIGITS  decimal point enables
- updateDigitMask  in  NUM_DIGITS  1 = digit may light
- updateBlinkMask  in  NUM_DIGITS  1 = digit blinks
- updateBrightness  in  BRIGHTNESS_BITS  0 = dark, MAX_LEVEL = full
- segmentEnableN  out  8  active-low segments {dp,g..a}
- digitEnableN  out  NUM_DIGITS  active-low anodes
- frameStart  out  1  one-cycle pulse on first cycle of digit-0 slot

## Operation
- Counters: slotCount 0..SLOT_CYCLES−1, digitIndex 0..NUM_DIGITS−1, blinkCount 0..BLINK_FRAMES−1, blinkPhase. slotCount wraps → digitIndex increments; digitIndex wraps with slotCount → frame boundary.
- Per-slot FSM: BLANK (slotCount < BLANK_CYCLES): all anodes off, segments off. ON (BLANK_CYCLES ≤ slotCount < BLANK_CYCLES + brightness*STEP_CYCLES): anode of digitIndex low if digitMask[digitIndex] and not (blinkPhase & blinkMask[digitIndex]). DARK (remainder of slot): all off. brightness 0 → never ON; MAX_LEVEL → ON to slot end.
- Segments: encoder(data[digitIndex*4+:4], point[digitIndex]) during ON; 8'hFF otherwise.
- Buffering: handshake (updateValid & updateReady) copies all update fields into shadow, sets pending, drops updateReady. At frame boundary, pending → active registers copied, pending cleared, updateReady high next cycle. Handshake and boundary in same cycle: boundary copies the old shadow state; new image becomes pending for next frame.
- Blink: at each frame boundary blinkCount increments; wrap toggles blinkPhase.
- updateValid held while updateReady low: no effect; no ordering requirement on deassert.

## Timing
- Reset (resetN low at a clock edge): all counters 0, blinkPhase 0, pending 0, active data/point/masks 0, brightness 0; outputs: segmentEnableN 8'hFF, digitEnableN all ones, updateReady 1, frameStart 0. Reset mid-frame discards active and shadow images.
- First cycle after reset release is slot 0 of digit 0; frameStart asserted in that cycle, then every FRAME_CYCLES.
- segmentEnableN/digitEnableN registered: reflect slotCount/digitIndex state one cycle later; no glitches; anode change only ever through an all-off cycle.
- Update latency: new image visible from first ON cycle of digit 0 in the frame after acceptance (+1 register cycle).

## Configuration
- SEVEN_SEGMENT_BLINK_EN defined: blink counter/phase implemented as above.
- Undefined: updateBlinkMask accepted but ignored, no blink logic synthesised, blinkPhase constant 0.

## Structure
- Package seven_segment_pkg: segment-off constant 8'hFF, FSM state enum {BLANK, ON, DARK}, derived-width helper functions (clog2-based counter widths).
- One sub-module: existing SevenSegmentEncoder instance; no other hierarchy.

## Test plan
Bench config NUM_DIGITS=4, BLANK_CYCLES=2, STEP_CYCLES=1, BRIGHTNESS_BITS=2 (SLOT=5, FRAME=20).
- Reset → digitEnableN 4'hF, segmentEnableN 8'hFF, updateReady 1, frameStart at cycle 0 and 20.
- Update data 16'h3210, masks 4'hF, brightness 3 → next frame each digit low 3 cycles after 2 blank; digit 1 segments = encoding of 1.
- Brightness 1 → each anode low exactly 1 cycle/slot; brightness 0 → anodes never low.
- Second updateValid before boundary → updateReady 0, ignored; accepted after boundary, applied one frame later.
- Handshake on boundary cycle → takes effect the following frame, not current.
- Blink (macro on, BLINK_FRAMES=2, blinkMask 4'b0100) → digit 2 dark frames 2–3, lit 4–5; macro off → always lit.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - shared constants, slot FSM states and counter-width helper for the display driver
package seven_segment_pkg;

    localparam logic [7:0] SEGMENTS_OFF = 8'hFF;

    typedef enum logic [1:0] {BLANK, ON, DARK} slot_state_t;

    // Width of a counter running 0..count-1, never narrower than one bit.
    function automatic int count_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/multiplexed_display_driver_if.sv
// rtl/multiplexed_display_driver_if.sv - valid/ready image update port of the multiplexed display driver
interface multiplexed_display_driver_if #(
    parameter int NUM_DIGITS      = 8,
    parameter int BRIGHTNESS_BITS = 4
);
    logic                        updateValid;
    logic                        updateReady;
    logic [4*NUM_DIGITS-1:0]     updateData;
    logic [NUM_DIGITS-1:0]       updatePoint;
    logic [NUM_DIGITS-1:0]       updateDigitMask;
    logic [NUM_DIGITS-1:0]       updateBlinkMask;
    logic [BRIGHTNESS_BITS-1:0]  updateBrightness;

    modport master (
        output updateValid, updateData, updatePoint, updateDigitMask,
               updateBlinkMask, updateBrightness,
        input  updateReady
    );

    modport slave (
        input  updateValid, updateData, updatePoint, updateDigitMask,
               updateBlinkMask, updateBrightness,
        output updateReady
    );
endinterface

// File: rtl/multiplexed_display_driver_encoder.sv
// rtl/multiplexed_display_driver_encoder.sv - SevenSegmentEncoder: hex nibble to active-low {dp,g..a} pattern
module SevenSegmentEncoder (
    input  logic [3:0] value,
    input  logic       point,
    output logic [7:0] segments
);
    logic [6:0] glyph;

    always_comb begin
        glyph = 7'h7F;
        case (value)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    assign segments = {~point, glyph};
endmodule

// File: rtl/multiplexed_display_driver.sv
// rtl/multiplexed_display_driver.sv - multiplexed common-anode scan driver with PWM, masks and double buffering
// Optional blink logic: define SEVEN_SEGMENT_BLINK_EN.
module multiplexed_display_driver
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS      = 8,
    parameter int BLANK_CYCLES    = 64,
    parameter int STEP_CYCLES     = 256,
    parameter int BRIGHTNESS_BITS = 4,
    parameter int BLINK_FRAMES    = 64
)(
    input  logic                   clock,
    input  logic                   resetN,
    multiplexed_display_driver_if.slave upd,
    output logic [7:0]             segmentEnableN,
    output logic [NUM_DIGITS-1:0]  digitEnableN,
    output logic                   frameStart
);
    localparam int MAX_LEVEL   = 2**BRIGHTNESS_BITS - 1;
    localparam int SLOT_CYCLES = BLANK_CYCLES + MAX_LEVEL*STEP_CYCLES;
    localparam int SLOT_W      = count_width(SLOT_CYCLES);
    localparam int DIGIT_W     = count_width(NUM_DIGITS);
    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    logic [SLOT_W-1:0]          slot_count;
    logic [DIGIT_W-1:0]         digit_index;
    logic                       pending;
    logic [4*NUM_DIGITS-1:0]    shadow_data, active_data;
    logic [NUM_DIGITS-1:0]      shadow_point, active_point;
    logic [NUM_DIGITS-1:0]      shadow_mask, active_mask;
    logic [BRIGHTNESS_BITS-1:0] shadow_brightness, active_brightness;
    logic [NUM_DIGITS-1:0]      blink_hide;

    slot_state_t                state, state_next;
    logic [7:0]                 glyph, seg_next;
    logic [NUM_DIGITS-1:0]      dig_next;
    logic                       frame_next;
    logic [SLOT_W-1:0]          on_last;
    logic                       handshake, frame_boundary;

    assign handshake       = upd.updateValid && !pending;
    assign frame_boundary  = (slot_count == SLOT_LAST) && (digit_index == DIGIT_LAST);
    assign upd.updateReady = ~pending;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            slot_count        <= '0;
            digit_index       <= '0;
            pending           <= 1'b0;
            shadow_data       <= '0;
            shadow_point      <= '0;
            shadow_mask       <= '0;
            shadow_brightness <= '0;
            active_data       <= '0;
            active_point      <= '0;
            active_mask       <= '0;
            active_brightness <= '0;
        end else begin
            if (slot_count == SLOT_LAST) begin
                slot_count  <= '0;
                digit_index <= (digit_index == DIGIT_LAST) ? '0 : digit_index + DIGIT_W'(1);
            end else begin
                slot_count  <= slot_count + SLOT_W'(1);
            end
            // Acceptance on the boundary cycle is safe: pending was clear, so nothing is copied now.
            if (frame_boundary && pending) begin
                active_data       <= shadow_data;
                active_point      <= shadow_point;
                active_mask       <= shadow_mask;
                active_brightness <= shadow_brightness;
            end
            if (handshake) begin
                shadow_data       <= upd.updateData;
                shadow_point      <= upd.updatePoint;
                shadow_mask       <= upd.updateDigitMask;
                shadow_brightness <= upd.updateBrightness;
                pending           <= 1'b1;
            end else if (frame_boundary) begin
                pending           <= 1'b0;
            end
        end
    end

`ifdef SEVEN_SEGMENT_BLINK_EN
    localparam int BLINK_W = count_width(BLINK_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0]    blink_count;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] shadow_blink, active_blink;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            blink_count  <= '0;
            blink_phase  <= 1'b0;
            shadow_blink <= '0;
            active_blink <= '0;
        end else begin
            if (handshake) shadow_blink <= upd.updateBlinkMask;
            if (frame_boundary) begin
                if (pending) active_blink <= shadow_blink;
                if (blink_count == BLINK_LAST) begin
                    blink_count <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_count <= blink_count + BLINK_W'(1);
                end
            end
        end
    end

    assign blink_hide = blink_phase ? active_blink : '0;
`else
    logic unused_blink;
    assign unused_blink = (^upd.updateBlinkMask) ^ BLINK_FRAMES[0];
    assign blink_hide   = '0;
`endif

    SevenSegmentEncoder encoder (
        .value    (active_data[int'(digit_index)*4 +: 4]),
        .point    (active_point[digit_index]),
        .segments (glyph)
    );

    assign on_last = SLOT_W'(BLANK_CYCLES - 1 + int'(active_brightness) * STEP_CYCLES);

    always_comb begin
        state_next = state;
        seg_next   = SEGMENTS_OFF;
        dig_next   = '1;
        frame_next = (slot_count == '0) && (digit_index == '0);
        case (state)
            BLANK: if (slot_count == BLANK_LAST)
                       state_next = (active_brightness != '0) ? ON : DARK;
            ON: begin
                if (slot_count == SLOT_LAST)   state_next = BLANK;
                else if (slot_count == on_last) state_next = DARK;
                seg_next = glyph;
                if (active_mask[digit_index] && !blink_hide[digit_index])
                    dig_next[digit_index] = 1'b0;
            end
            DARK:  if (slot_count == SLOT_LAST) state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // Outputs are registered so the pins never see decode glitches.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state          <= BLANK;
            segmentEnableN <= SEGMENTS_OFF;
            digitEnableN   <= '1;
            frameStart     <= 1'b0;
        end else begin
            state          <= state_next;
            segmentEnableN <= seg_next;
            digitEnableN   <= dig_next;
            frameStart     <= frame_next;
        end
    end
endmodule

// File: tb/tb_multiplexed_display_driver.sv
// tb/tb_multiplexed_display_driver.sv - scoreboard bench for multiplexed_display_driver (4 digits, 5-cycle slots)
module tb_multiplexed_display_driver;
    localparam int NF = 10;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  point;
        logic [3:0]  lit;
        logic [1:0]  br;
    } frame_t;

    logic clock = 1'b0;
    logic resetN;
    logic [7:0] segmentEnableN;
    logic [3:0] digitEnableN;
    logic frameStart;
    int checks = 0;
    int errors = 0;
    frame_t exp_q[$];
    frame_t exp_tab[NF];

    multiplexed_display_driver_if #(.NUM_DIGITS(4), .BRIGHTNESS_BITS(2)) upd ();

    multiplexed_display_driver #(
        .NUM_DIGITS(4), .BLANK_CYCLES(2), .STEP_CYCLES(1),
        .BRIGHTNESS_BITS(2), .BLINK_FRAMES(2)
    ) dut (
        .clock(clock), .resetN(resetN), .upd(upd),
        .segmentEnableN(segmentEnableN), .digitEnableN(digitEnableN), .frameStart(frameStart)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] nib, input logic pt);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        if (pt) s[7] = 1'b0;
        return s;
    endfunction

    // Slot = 2 blank cycles then up to 3 on-cycles; cycle t of a frame belongs to digit t/5.
    function automatic logic is_on(input frame_t e, input int t);
        int s = t % 5;
        return (s >= 2) && ((s - 2) < int'(e.br));
    endfunction

    function automatic logic [3:0] exp_anodes(input frame_t e, input int t);
        logic [3:0] a = 4'hF;
        int d = t / 5;
        if (is_on(e, t) && e.lit[d]) a[d] = 1'b0;
        return a;
    endfunction

    function automatic logic [7:0] exp_segs(input frame_t e, input int t);
        int d = t / 5;
        logic [15:0] dd = e.data;
        logic [3:0] pp = e.point;
        return is_on(e, t) ? enc(dd[d*4 +: 4], pp[d]) : 8'hFF;
    endfunction

    task automatic drive(input logic [15:0] data, input logic [3:0] pt, input logic [3:0] mask,
                         input logic [3:0] blink, input logic [1:0] br);
        upd.updateValid      = 1'b1;
        upd.updateData       = data;
        upd.updatePoint      = pt;
        upd.updateDigitMask  = mask;
        upd.updateBlinkMask  = blink;
        upd.updateBrightness = br;
    endtask

    task automatic stimulus();
        for (int f = 0; f < NF; f++) begin
            for (int t = 0; t < 20; t++) begin
                if (f != 0 || t != 0) @(negedge clock);
                if (t == 0) exp_q.push_back(exp_tab[f]);
                if (f == 0 && t == 2)  drive(16'h3210, 4'b0000, 4'hF, 4'b0000, 2'd3);
                if (f == 0 && t == 3) begin
                    check("ready_after_accept", 32'(upd.updateReady), 0);
                    drive(16'h9876, 4'b0101, 4'b1011, 4'b0000, 2'd1);
                end
                if (f == 0 && t == 10) check("ready_held_low", 32'(upd.updateReady), 0);
                if (f == 0 && t == 19) check("ready_after_boundary", 32'(upd.updateReady), 1);
                if (f == 1 && t == 0) begin
                    check("second_accepted", 32'(upd.updateReady), 0);
                    upd.updateValid = 1'b0;
                end
                if (f == 2 && t == 5)  drive(16'h1111, 4'b0000, 4'hF, 4'b0000, 2'd0);
                if (f == 2 && t == 6) begin
                    upd.updateValid = 1'b0;
                    check("ready_after_third", 32'(upd.updateReady), 0);
                end
                if (f == 3 && t == 18) begin
                    check("ready_before_boundary", 32'(upd.updateReady), 1);
                    drive(16'h4E2F, 4'b1000, 4'hF, 4'b0000, 2'd2);
                end
                if (f == 3 && t == 19) begin
                    upd.updateValid = 1'b0;
                    check("boundary_accept", 32'(upd.updateReady), 0);
                end
                if (f == 5 && t == 3)  drive(16'h8888, 4'b0000, 4'hF, 4'b0100, 2'd3);
                if (f == 5 && t == 4)  upd.updateValid = 1'b0;
            end
        end
    endtask

    task automatic monitor();
        logic [3:0] an_s[20];
        logic [7:0] sg_s[20];
        logic       fs_s[20];
        frame_t e;
        for (int f = 0; f < NF; f++) begin
            for (int t = 0; t < 20; t++) begin
                if (f != 0 || t != 0) @(negedge clock);
                an_s[t] = digitEnableN;
                sg_s[t] = segmentEnableN;
                fs_s[t] = frameStart;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL f%0d_scoreboard: got empty queue expected frame record", f);
            end else begin
                e = exp_q.pop_front();
                for (int t = 0; t < 20; t++) begin
                    check($sformatf("f%0d_t%0d_anodes", f, t), 32'(an_s[t]), 32'(exp_anodes(e, t)));
                    check($sformatf("f%0d_t%0d_segments", f, t), 32'(sg_s[t]), 32'(exp_segs(e, t)));
                    check($sformatf("f%0d_t%0d_frame_start", f, t), 32'(fs_s[t]), (t == 0) ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        bit found;
        int fs_seen;
        int low_seen;
        exp_tab[0] = '{16'h0000, 4'b0000, 4'b0000, 2'd0};
        exp_tab[1] = '{16'h3210, 4'b0000, 4'b1111, 2'd3};
        exp_tab[2] = '{16'h9876, 4'b0101, 4'b1011, 2'd1};
        exp_tab[3] = '{16'h1111, 4'b0000, 4'b1111, 2'd0};
        exp_tab[4] = '{16'h1111, 4'b0000, 4'b1111, 2'd0};
        exp_tab[5] = '{16'h4E2F, 4'b1000, 4'b1111, 2'd2};
`ifdef SEVEN_SEGMENT_BLINK_EN
        exp_tab[6] = '{16'h8888, 4'b0000, 4'b1011, 2'd3};
        exp_tab[7] = '{16'h8888, 4'b0000, 4'b1011, 2'd3};
`else
        exp_tab[6] = '{16'h8888, 4'b0000, 4'b1111, 2'd3};
        exp_tab[7] = '{16'h8888, 4'b0000, 4'b1111, 2'd3};
`endif
        exp_tab[8] = '{16'h8888, 4'b0000, 4'b1111, 2'd3};
        exp_tab[9] = '{16'h8888, 4'b0000, 4'b1111, 2'd3};

        resetN = 1'b0;
        upd.updateValid = 1'b0;
        upd.updateData = '0;
        upd.updatePoint = '0;
        upd.updateDigitMask = '0;
        upd.updateBlinkMask = '0;
        upd.updateBrightness = '0;
        repeat (3) @(negedge clock);
        check("reset_anodes", 32'(digitEnableN), 32'hF);
        check("reset_segments", 32'(segmentEnableN), 32'hFF);
        check("reset_ready", 32'(upd.updateReady), 1);
        check("reset_frame_start", 32'(frameStart), 0);
        resetN = 1'b1;

        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clock);
            if (frameStart) found = 1;
        end
        if (!found) begin
            $display("FAIL first_frame_start: got none expected pulse within 50 cycles");
            $fatal(1, "no frameStart");
        end

        fork
            stimulus();
            monitor();
        join

        // Mid-frame reset right after a new image is accepted must discard it.
        repeat (7) @(negedge clock);
        drive(16'h8765, 4'b1111, 4'hF, 4'b0000, 2'd3);
        @(negedge clock);
        upd.updateValid = 1'b0;
        check("accept_before_reset", 32'(upd.updateReady), 0);
        resetN = 1'b0;
        @(negedge clock);
        check("midreset_anodes", 32'(digitEnableN), 32'hF);
        check("midreset_segments", 32'(segmentEnableN), 32'hFF);
        check("midreset_ready", 32'(upd.updateReady), 1);
        check("midreset_frame_start", 32'(frameStart), 0);
        resetN = 1'b1;
        fs_seen = 0;
        low_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (i == 0)  check("restart_frame_start_0", 32'(frameStart), 1);
            if (i == 20) check("restart_frame_start_20", 32'(frameStart), 1);
            if (frameStart) fs_seen++;
            if (digitEnableN != 4'hF) low_seen++;
        end
        check("restart_frame_start_count", 32'(fs_seen), 2);
        check("restart_discarded_image", 32'(low_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
